// File: rtl/alu_op_sequencer.sv
// Feeds opcode and operands, collected as three words, to a 4-bit combinational ALU.
// Registers the result with a divide-by-zero substitute and hands it off on a valid/ready stream.
module alu_op_sequencer #(
  parameter logic [3:0] DIV0_RESULT = 4'hF,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       alu_oc,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_f,
  output logic [3:0]       res_data,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_OC   = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  localparam logic [2:0] OP_DIV = 3'b011;

  state_e           state_q;
  logic [2:0]       oc_q;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [3:0]       res_data_q;
  logic             res_err_q;
  logic             res_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic in_xfer;
  logic out_xfer;
  logic div0;

  assign in_ready = (state_q == S_OC) || (state_q == S_A) || (state_q == S_B);
  assign busy     = (state_q != S_OC);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = res_valid_q & res_ready;
  assign div0     = (oc_q == OP_DIV) && (b_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OC;
      oc_q        <= 3'd0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      res_data_q  <= 4'd0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else if (flush) begin
      // Abort wins over every handshake; operand and result registers keep their contents.
      state_q     <= S_OC;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_OC: begin
          if (in_xfer) begin
            oc_q    <= in_data[2:0];
            state_q <= S_A;
          end
        end
        S_A: begin
          if (in_xfer) begin
            a_q     <= in_data;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (in_xfer) begin
            b_q     <= in_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // alu_f has had a full cycle to settle from the stable operand registers.
          if (div0) begin
            res_data_q <= DIV0_RESULT;
            res_err_q  <= 1'b1;
          end else begin
            res_data_q <= alu_f;
            res_err_q  <= 1'b0;
          end
          res_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_xfer) begin
            res_valid_q <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
            state_q     <= S_OC;
          end
        end
        default: begin
          state_q     <= S_OC;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_oc    = oc_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;
  assign op_count  = cnt_q;

endmodule
